riscv_loader: RTL and testbench

RISCV_LOADER -- requirements
Module: riscv_loader

---
 rtl/riscv_loader_if.sv | 29 ++
 rtl/riscv_loader.sv | 145 ++++++++++++++
 tb/tb_riscv_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_loader_if.sv
// rtl/riscv_loader_if.sv - byte-stream input and RAM write port bundle for the boot loader
interface riscv_loader_if #(
   parameter int WORD_LENGTH = 32
);
   logic [7:0]             in_data;
   logic                   in_valid;
   logic                   in_ready;
   logic [WORD_LENGTH-1:0] addr;
   logic                   write_en;
   logic [WORD_LENGTH-1:0] wdata;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  addr,
      input  write_en,
      input  wdata
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output addr,
      output write_en,
      output wdata
   );
endinterface

// File: rtl/riscv_loader.sv
// rtl/riscv_loader.sv - loads a length-prefixed little-endian word image from a byte stream into RAM
// while holding the core in reset; all outputs are registered.
module riscv_loader #(
   parameter int WORD_LENGTH = 32,
   parameter int ADDR_LENGTH = 5,
   parameter int NUM_MEM     = 32
) (
   input  logic           clk,
   input  logic           rst,
   riscv_loader_if.slave  bus,
   output logic           cpu_hold,
   output logic           done,
   output logic           error
);

   typedef enum logic [2:0] {
      HDR_LO,
      HDR_HI,
      DATA,
      WRITE,
      DONE,
      ERR
   } state_t;

   state_t                 state_q;
   logic [15:0]            cnt_q;
   logic [ADDR_LENGTH-1:0] word_idx_q;
   logic [1:0]             byte_idx_q;
   logic [WORD_LENGTH-1:0] word_q;
   logic [WORD_LENGTH-1:0] addr_q;
   logic [WORD_LENGTH-1:0] wdata_q;
   logic                   write_en_q;
   logic                   in_ready_q;
   logic                   cpu_hold_q;
   logic                   done_q;
   logic                   error_q;

   logic                   accept;
   logic [15:0]            hdr_n_d;
   logic [15:0]            next_idx_d;
   logic [WORD_LENGTH-1:0] word_d;

   // in_ready_q always matches the current state, so it doubles as the accept gate
   assign accept = bus.in_valid && in_ready_q;

   always_comb begin
      hdr_n_d    = {bus.in_data, cnt_q[7:0]};
      next_idx_d = 16'(word_idx_q) + 16'd1;
      word_d     = word_q;
      word_d[{byte_idx_q, 3'b000} +: 8] = bus.in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= HDR_LO;
         cnt_q      <= '0;
         word_idx_q <= '0;
         byte_idx_q <= '0;
         word_q     <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         write_en_q <= 1'b0;
         in_ready_q <= 1'b1;
         cpu_hold_q <= 1'b1;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         write_en_q <= 1'b0;
         case (state_q)
            HDR_LO: begin
               if (accept) begin
                  cnt_q[7:0] <= bus.in_data;
                  state_q    <= HDR_HI;
               end
            end

            HDR_HI: begin
               if (accept) begin
                  cnt_q <= hdr_n_d;
                  if (hdr_n_d == 16'd0) begin
                     state_q    <= DONE;
                     in_ready_q <= 1'b0;
                     cpu_hold_q <= 1'b0;
                     done_q     <= 1'b1;
                  end else if (hdr_n_d > 16'(NUM_MEM)) begin
                     state_q    <= ERR;
                     in_ready_q <= 1'b0;
                     error_q    <= 1'b1;
                  end else begin
                     state_q    <= DATA;
                     word_idx_q <= '0;
                     byte_idx_q <= '0;
                  end
               end
            end

            // the RAM strobe is launched together with the 4th byte so it lands in the WRITE cycle
            DATA: begin
               if (accept) begin
                  word_q     <= word_d;
                  byte_idx_q <= byte_idx_q + 2'd1;
                  if (byte_idx_q == 2'd3) begin
                     state_q    <= WRITE;
                     in_ready_q <= 1'b0;
                     write_en_q <= 1'b1;
                     addr_q     <= WORD_LENGTH'(word_idx_q);
                     wdata_q    <= word_d;
                  end
               end
            end

            WRITE: begin
               if (next_idx_d == cnt_q) begin
                  state_q    <= DONE;
                  cpu_hold_q <= 1'b0;
                  done_q     <= 1'b1;
               end else begin
                  word_idx_q <= word_idx_q + 1'b1;
                  state_q    <= DATA;
                  in_ready_q <= 1'b1;
               end
            end

            DONE: begin
            end

            ERR: begin
            end

            default: begin
               state_q <= HDR_LO;
            end
         endcase
      end
   end

   assign bus.in_ready = in_ready_q;
   assign bus.addr     = addr_q;
   assign bus.write_en = write_en_q;
   assign bus.wdata    = wdata_q;
   assign cpu_hold     = cpu_hold_q;
   assign done         = done_q;
   assign error        = error_q;

endmodule

// File: tb/tb_riscv_loader.sv
// tb/tb_riscv_loader.sv - scoreboard bench for riscv_loader: expected RAM writes queued at stimulus time
module tb_riscv_loader;
   localparam int WL = 32;
   localparam int AL = 5;
   localparam int NM = 32;

   logic clk = 1'b0;
   logic rst;
   logic cpu_hold;
   logic done;
   logic error;

   always #5 clk = ~clk;

   riscv_loader_if #(.WORD_LENGTH(WL)) bus ();

   riscv_loader #(
      .WORD_LENGTH(WL),
      .ADDR_LENGTH(AL),
      .NUM_MEM    (NM)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .cpu_hold(cpu_hold),
      .done    (done),
      .error   (error)
   );

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          wr_count = 0;
   int          last_wr_cyc = -10;
   bit [63:0]   sb[$];
   bit [63:0]   sb_exp;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst && bus.write_en) begin
         wr_count++;
         last_wr_cyc = cyc;
         check_eq("wr_in_ready_low", bus.in_ready, 0);
         if (sb.size() == 0) begin
            check_eq("spurious_wr", bus.write_en, 0);
         end else begin
            sb_exp = sb.pop_front();
            check_eq("wr_addr", bus.addr, sb_exp[63:32]);
            check_eq("wr_data", bus.wdata, sb_exp[31:0]);
         end
      end
   end

   // a byte is presented during the reset edge and must be discarded
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data = 8'h05;
      @(negedge clk);
      rst = 1'b0;
      bus.in_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      repeat (gap) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data = b;
      n = 0;
      while (!bus.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check_eq("send_timeout", bus.in_ready, 1);
   endtask

   task automatic send_word(input logic [31:0] w, input int maxgap);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], $urandom_range(0, maxgap));
   endtask

   task automatic idle();
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_eq("done_seen", done, 1);
   endtask

   task automatic push_junk(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data = 8'($urandom);
      end
      idle();
   endtask

   logic [31:0] w;

   initial begin
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data = 8'h00;

      do_reset();
      check_eq("rst_in_ready", bus.in_ready, 1);
      check_eq("rst_cpu_hold", cpu_hold, 1);
      check_eq("rst_done", done, 0);
      check_eq("rst_error", error, 0);
      check_eq("rst_write_en", bus.write_en, 0);
      check_eq("rst_addr", bus.addr, 0);
      check_eq("rst_wdata", bus.wdata, 0);

      // two-word image streamed back-to-back
      sb.push_back({32'd0, 32'h00A00513});
      sb.push_back({32'd1, 32'h0000006F});
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_word(32'h00A00513, 0);
      send_word(32'h0000006F, 0);
      idle();
      wait_done();
      check_eq("done_latency", cyc - last_wr_cyc, 1);
      check_eq("done_cpu_hold", cpu_hold, 0);
      check_eq("done_in_ready", bus.in_ready, 0);
      check_eq("img2_wr_count", wr_count, 2);
      check_eq("img2_sb_empty", sb.size(), 0);
      push_junk(6);
      check_eq("done_sticky", done, 1);
      check_eq("done_no_more_wr", wr_count, 2);

      // empty image
      do_reset();
      wr_count = 0;
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      idle();
      wait_done();
      check_eq("empty_cpu_hold", cpu_hold, 0);
      check_eq("empty_error", error, 0);
      @(negedge clk);
      check_eq("empty_wr_count", wr_count, 0);

      // oversized image
      do_reset();
      wr_count = 0;
      send_byte(8'h21, 0);
      send_byte(8'h00, 0);
      idle();
      check_eq("err_error", error, 1);
      check_eq("err_cpu_hold", cpu_hold, 1);
      check_eq("err_in_ready", bus.in_ready, 0);
      check_eq("err_done", done, 0);
      push_junk(8);
      check_eq("err_sticky", error, 1);
      check_eq("err_wr_count", wr_count, 0);

      // full RAM with random valid gaps
      do_reset();
      wr_count = 0;
      send_byte(8'h20, 2);
      send_byte(8'h00, 1);
      for (int i = 0; i < 32; i++) begin
         w = $urandom;
         sb.push_back({32'(i), w});
         send_word(w, 3);
      end
      idle();
      wait_done();
      check_eq("full_wr_count", wr_count, 32);
      check_eq("full_sb_empty", sb.size(), 0);

      // reset in the middle of word 1, then a fresh one-word image
      do_reset();
      wr_count = 0;
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      w = 32'h12345678;
      sb.push_back({32'd0, w});
      send_word(w, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      do_reset();
      check_eq("midrst_addr", bus.addr, 0);
      check_eq("midrst_wdata", bus.wdata, 0);
      check_eq("midrst_in_ready", bus.in_ready, 1);
      check_eq("midrst_cpu_hold", cpu_hold, 1);
      check_eq("midrst_wr_count", wr_count, 1);
      sb.push_back({32'd0, 32'hEFBEADDE});
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'hDE, 0);
      send_byte(8'hAD, 0);
      send_byte(8'hBE, 0);
      send_byte(8'hEF, 0);
      idle();
      wait_done();
      check_eq("fresh_wr_count", wr_count, 2);
      check_eq("fresh_sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
